// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked ripple-carry adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk_of(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk counter width; a single-chunk adder still gets a 1-bit counter.
  function automatic int cnt_width_of(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// N-bit ripple chain of full-adder cells; also exposes the carry into the top bit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);
  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[N];
  assign c_msb_in = c[N-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock through one shared ripple chain.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input logic              clk,
  input logic              rst,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
  localparam int CW     = cnt_width_of(WIDTH, CHUNK);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             cout_reg;
  logic             ovf_reg;
  logic [CW-1:0]    cnt;
  logic             last;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] s_slice;
  logic             c_out;
  logic             c_msb;

  assign a_slice = a_reg[cnt*CHUNK +: CHUNK];
  assign b_slice = b_reg[cnt*CHUNK +: CHUNK];
  assign last    = (cnt == CW'(NCHUNK - 1));

  chunk_adder #(.N(CHUNK)) u_chunk (
    .a        (a_slice),
    .b        (b_slice),
    .cin      (carry),
    .s        (s_slice),
    .cout     (c_out),
    .c_msb_in (c_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = ADD;
      ADD:     if (last) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter returns to 0 after the final chunk so the slice index never leaves the operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        ADD: begin
          sum_reg[cnt*CHUNK +: CHUNK] <= s_slice;
          carry <= c_out;
          if (last) begin
            cout_reg <= c_out;
            ovf_reg  <= c_msb ^ c_out;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: four adder configurations against an arithmetic reference.
module tb_seq_chunk_adder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    int          sel;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  seq_chunk_adder_if #(.WIDTH(64)) if0 ();
  seq_chunk_adder_if #(.WIDTH(16)) if1 ();
  seq_chunk_adder_if #(.WIDTH(64)) if2 ();
  seq_chunk_adder_if #(.WIDTH(16)) if3 ();

  seq_chunk_adder #(.WIDTH(64), .CHUNK(8))  u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  seq_chunk_adder #(.WIDTH(64), .CHUNK(64)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int widthOf(input int sel);
    return (sel == 1 || sel == 3) ? 16 : 64;
  endfunction

  function automatic int nchunkOf(input int sel);
    case (sel)
      0:       return 8;
      1:       return 4;
      2:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [63:0] maskOf(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: plain integer addition, signed overflow from operand/result signs.
  function automatic void refModel(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, output logic [63:0] s,
                                   output logic co, output logic ov);
    logic [64:0] full;
    logic [63:0] m;
    m    = maskOf(w);
    full = {1'b0, a & m} + {1'b0, b & m} + {64'd0, cin};
    s    = full[63:0] & m;
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic applyStimulus(input int sel, input logic iv, input logic [63:0] a,
                               input logic [63:0] b, input logic cin, input logic ordy);
    case (sel)
      0: begin if0.in_valid = iv; if0.a = a;       if0.b = b;       if0.cin = cin; if0.out_ready = ordy; end
      1: begin if1.in_valid = iv; if1.a = a[15:0]; if1.b = b[15:0]; if1.cin = cin; if1.out_ready = ordy; end
      2: begin if2.in_valid = iv; if2.a = a;       if2.b = b;       if2.cin = cin; if2.out_ready = ordy; end
      default: begin if3.in_valid = iv; if3.a = a[15:0]; if3.b = b[15:0]; if3.cin = cin; if3.out_ready = ordy; end
    endcase
  endtask

  task automatic sampleOutputs(input int sel, output logic rdy, output logic vld,
                               output logic [63:0] s, output logic co, output logic ov);
    case (sel)
      0: begin rdy = if0.in_ready; vld = if0.out_valid; s = if0.sum;          co = if0.cout; ov = if0.overflow; end
      1: begin rdy = if1.in_ready; vld = if1.out_valid; s = {48'd0, if1.sum}; co = if1.cout; ov = if1.overflow; end
      2: begin rdy = if2.in_ready; vld = if2.out_valid; s = if2.sum;          co = if2.cout; ov = if2.overflow; end
      default: begin rdy = if3.in_ready; vld = if3.out_valid; s = {48'd0, if3.sum}; co = if3.cout; ov = if3.overflow; end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE (#1 after an edge), issues one op with out_ready high, ends back in IDLE.
  task automatic runOp(input int sel, input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic [63:0] es, input logic ec, input logic eo, input string tag);
    int          n;
    int          lat;
    logic        rdy, vld, co, ov;
    logic [63:0] s;
    n = nchunkOf(sel);
    sampleOutputs(sel, rdy, vld, s, co, ov);
    checkOutput({tag, " in_ready"}, {63'd0, rdy}, 64'd1);
    applyStimulus(sel, 1'b1, a, b, cin, 1'b1);
    tick();
    applyStimulus(sel, 1'b0, ~a, ~b, ~cin, 1'b1);
    lat = 0;
    sampleOutputs(sel, rdy, vld, s, co, ov);
    while (!vld && lat < n + 4) begin
      tick();
      lat++;
      sampleOutputs(sel, rdy, vld, s, co, ov);
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(n));
    checkOutput({tag, " sum"}, s, es);
    checkOutput({tag, " cout"}, {63'd0, co}, {63'd0, ec});
    checkOutput({tag, " overflow"}, {63'd0, ov}, {63'd0, eo});
    tick();
    sampleOutputs(sel, rdy, vld, s, co, ov);
    checkOutput({tag, " out_valid clear"}, {63'd0, vld}, 64'd0);
  endtask

  initial begin
    logic        rdy, vld, co, ov;
    logic [63:0] s;
    logic [63:0] ra, rb, es;
    logic        rc, ec, eo;
    int          lat;

    checks = 0;
    errors = 0;
    for (int k = 0; k < 4; k++) applyStimulus(k, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

    vecs[0] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
    vecs[1] = '{1, 64'h7FFF, 64'h0001, 1'b0, 64'h8000, 1'b0, 1'b1};
    vecs[2] = '{1, 64'h8000, 64'h8000, 1'b0, 64'h0000, 1'b1, 1'b1};
    vecs[3] = '{2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{3, 64'hFFFF, 64'hFFFF, 1'b1, 64'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sampleOutputs(k, rdy, vld, s, co, ov);
      checkOutput($sformatf("reset%0d in_ready", k), {63'd0, rdy}, 64'd1);
      checkOutput($sformatf("reset%0d out_valid", k), {63'd0, vld}, 64'd0);
      checkOutput($sformatf("reset%0d sum", k), s, 64'd0);
      checkOutput($sformatf("reset%0d cout/ovf", k), {62'd0, co, ov}, 64'd0);
    end

    $display("[TB] directed vectors");
    for (int i = 0; i < 6; i++)
      runOp(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    $display("[TB] backpressure hold");
    applyStimulus(1, 1'b1, 64'h1234, 64'h0F0F, 1'b1, 1'b0);
    tick();
    applyStimulus(1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    lat = 0;
    sampleOutputs(1, rdy, vld, s, co, ov);
    while (!vld && lat < 8) begin
      tick();
      lat++;
      sampleOutputs(1, rdy, vld, s, co, ov);
    end
    checkOutput("hold latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, 64'hAAAA, 64'h5555, 1'b1, 1'b0);
      tick();
      sampleOutputs(1, rdy, vld, s, co, ov);
      checkOutput($sformatf("hold%0d out_valid", i), {63'd0, vld}, 64'd1);
      checkOutput($sformatf("hold%0d in_ready", i), {63'd0, rdy}, 64'd0);
      checkOutput($sformatf("hold%0d sum", i), s, 64'h2144);
      checkOutput($sformatf("hold%0d cout/ovf", i), {62'd0, co, ov}, 64'd0);
    end
    applyStimulus(1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    tick();
    sampleOutputs(1, rdy, vld, s, co, ov);
    checkOutput("release out_valid", {63'd0, vld}, 64'd0);
    checkOutput("release in_ready", {63'd0, rdy}, 64'd1);
    tick();
    sampleOutputs(1, rdy, vld, s, co, ov);
    checkOutput("no stray op", {63'd0, rdy}, 64'd1);

    $display("[TB] reset during ADD");
    applyStimulus(1, 1'b1, 64'h1234, 64'h1111, 1'b0, 1'b1);
    tick();
    applyStimulus(1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sampleOutputs(1, rdy, vld, s, co, ov);
    checkOutput("abort in_ready", {63'd0, rdy}, 64'd1);
    checkOutput("abort out_valid", {63'd0, vld}, 64'd0);
    checkOutput("abort sum", s, 64'd0);
    runOp(1, 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0, "post-abort");

    $display("[TB] random regression");
    for (int k = 0; k < 4; k++) begin
      if (k == 1) continue;
      for (int i = 0; i < 1000; i++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom_range(1, 0));
        if (i % 50 == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
        if (i % 50 == 1) begin ra = 64'h8000_0000_0000_0000; rb = ra; end
        ra = ra & maskOf(widthOf(k));
        rb = rb & maskOf(widthOf(k));
        refModel(widthOf(k), ra, rb, rc, es, ec, eo);
        runOp(k, ra, rb, rc, es, ec, eo, $sformatf("rand%0d_%0d", k, i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
